// File: rtl/usb_bit_encoder.sv
// Full-speed USB transmit stage: CRC append, bit stuffing, NRZI encoding and EOP generation.
// Build option USB_ENC_CRC_EN: generate CRC5/CRC16 internally; otherwise CRC fields are sent verbatim from pkt_in.

module usb_bit_encoder #(
    parameter int STUFF_RUN   = 6,
    parameter int EOP_SE0_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [98:0] pkt_in,
    input  logic        pkt_in_avail,
    output logic        pkt_sent,
    output logic        pkt_err,
    output logic        busy,
    output logic        dp,
    output logic        dm,
    output logic        bus_oe
);
    localparam int               RUN_W   = $clog2(STUFF_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_RUN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_EOP_SE0,
        ST_EOP_J,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        CLS_HS,
        CLS_TOKEN,
        CLS_DATA,
        CLS_BAD
    } cls_t;

    state_t           state_q, state_d;
    logic [98:0]      sh_q, sh_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             line_q, line_d;     // 1 = J, 0 = K
    logic [3:0]       pid;
    cls_t             pid_cls;
    logic             stuff, raw_bit, tx_bit, lvl;
`ifdef USB_ENC_CRC_EN
    cls_t             cls_q, cls_d;
    logic [4:0]       crc5_q, crc5_d;
    logic [15:0]      crc16_q, crc16_d;
    logic             in_pay, in_crc;
`endif

    always_comb begin
        pid = {pkt_in[87], pkt_in[88], pkt_in[89], pkt_in[90]};
        case (pid)
            4'b0001, 4'b1001: pid_cls = CLS_TOKEN;
            4'b0011, 4'b1011: pid_cls = CLS_DATA;
            4'b0010, 4'b1010: pid_cls = CLS_HS;
            default:          pid_cls = CLS_BAD;
        endcase
    end

    // cnt_q holds the raw bits still to send, so the CRC field is the last 5/16 of them
    always_comb begin
        stuff = (run_q == RUN_MAX);
`ifdef USB_ENC_CRC_EN
        in_pay = ((cls_q == CLS_TOKEN) && (cnt_q <= 7'd16) && (cnt_q > 7'd5)) ||
                 ((cls_q == CLS_DATA)  && (cnt_q <= 7'd80) && (cnt_q > 7'd16));
        in_crc = ((cls_q == CLS_TOKEN) && (cnt_q <= 7'd5)) ||
                 ((cls_q == CLS_DATA)  && (cnt_q <= 7'd16));
        if (in_crc) begin
            raw_bit = (cls_q == CLS_TOKEN) ? ~crc5_q[4] : ~crc16_q[15];
        end else begin
            raw_bit = sh_q[98];
        end
`else
        raw_bit = sh_q[98];
`endif
        tx_bit = stuff ? 1'b0 : raw_bit;
        lvl    = tx_bit ? line_q : ~line_q;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        line_d  = line_q;
`ifdef USB_ENC_CRC_EN
        cls_d   = cls_q;
        crc5_d  = crc5_q;
        crc16_d = crc16_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pkt_in_avail) begin
                    sh_d   = pkt_in;
                    run_d  = '0;
                    line_d = 1'b1;
`ifdef USB_ENC_CRC_EN
                    cls_d   = pid_cls;
                    crc5_d  = '1;
                    crc16_d = '1;
`endif
                    case (pid_cls)
                        CLS_TOKEN: begin cnt_d = 7'd32; state_d = ST_SEND; end
                        CLS_DATA:  begin cnt_d = 7'd96; state_d = ST_SEND; end
                        CLS_HS:    begin cnt_d = 7'd16; state_d = ST_SEND; end
                        default:   state_d = ST_ERR;
                    endcase
                end
            end
            ST_SEND: begin
                line_d = lvl;
                if (stuff) begin
                    run_d = '0;
                end else begin
                    sh_d  = {sh_q[97:0], 1'b0};
                    cnt_d = cnt_q - 7'd1;
                    run_d = raw_bit ? run_q + RUN_W'(1) : '0;
`ifdef USB_ENC_CRC_EN
                    if (in_pay) begin
                        crc5_d  = {crc5_q[3:0], 1'b0} ^ ((raw_bit ^ crc5_q[4]) ? 5'h05 : 5'h00);
                        crc16_d = {crc16_q[14:0], 1'b0} ^ ((raw_bit ^ crc16_q[15]) ? 16'h8005 : 16'h0000);
                    end else if (in_crc) begin
                        crc5_d  = {crc5_q[3:0], 1'b1};
                        crc16_d = {crc16_q[14:0], 1'b1};
                    end
`endif
                end
                // a run completed by the last bit still owes one stuff cycle before EOP
                if ((cnt_d == 7'd0) && (run_d != RUN_MAX)) begin
                    state_d = ST_EOP_SE0;
                    cnt_d   = 7'(EOP_SE0_LEN - 1);
                    line_d  = 1'b1;
                end
            end
            ST_EOP_SE0: begin
                if (cnt_q == 7'd0) begin
                    state_d = ST_EOP_J;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            ST_EOP_J: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dp       = 1'b1;
        dm       = 1'b0;
        bus_oe   = 1'b0;
        busy     = (state_q != ST_IDLE);
        pkt_sent = (state_q == ST_DONE);
        pkt_err  = (state_q == ST_ERR);
        case (state_q)
            ST_SEND: begin
                dp     = lvl;
                dm     = ~lvl;
                bus_oe = 1'b1;
            end
            ST_EOP_SE0: begin
                dp     = 1'b0;
                dm     = 1'b0;
                bus_oe = 1'b1;
            end
            ST_EOP_J: bus_oe = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            line_q  <= 1'b1;
`ifdef USB_ENC_CRC_EN
            cls_q   <= CLS_HS;
            crc5_q  <= '1;
            crc16_q <= '1;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            line_q  <= line_d;
`ifdef USB_ENC_CRC_EN
            cls_q   <= cls_d;
            crc5_q  <= crc5_d;
            crc16_q <= crc16_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb_bit_encoder.sv
// Scoreboard bench for usb_bit_encoder: per-cycle line/handshake expectations plus decode of the driven wire.
// Honors USB_ENC_CRC_EN the same way as the design.

module tb_usb_bit_encoder;
    localparam int STUFF_RUN   = 6;
    localparam int EOP_SE0_LEN = 2;

    // {busy, bus_oe, dp, dm, pkt_sent, pkt_err}
    localparam logic [5:0] E_IDLE = 6'b001000;
    localparam logic [5:0] E_SE0  = 6'b110000;
    localparam logic [5:0] E_J    = 6'b111000;
    localparam logic [5:0] E_DONE = 6'b101010;
    localparam logic [5:0] E_ERR  = 6'b101001;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [98:0] pkt_in;
    logic        pkt_in_avail;
    logic        pkt_sent, pkt_err, busy, dp, dm, bus_oe;
    logic [5:0]  obs;

    always #5 clk = ~clk;

    usb_bit_encoder #(
        .STUFF_RUN  (STUFF_RUN),
        .EOP_SE0_LEN(EOP_SE0_LEN)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .pkt_in      (pkt_in),
        .pkt_in_avail(pkt_in_avail),
        .pkt_sent    (pkt_sent),
        .pkt_err     (pkt_err),
        .busy        (busy),
        .dp          (dp),
        .dm          (dm),
        .bus_oe      (bus_oe)
    );

    assign obs = {busy, bus_oe, dp, dm, pkt_sent, pkt_err};

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [5:0] sb[$];
    logic       cap[$];
    bit         mdl_body[$];
    int         mdl_plen, mdl_clen;
    logic       se0_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

`ifdef USB_ENC_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit d, input int w);
        logic [15:0] poly, mask;
        logic        fb;
        poly = (w == 5) ? 16'h0005 : 16'h8005;
        mask = (w == 5) ? 16'h001F : 16'hFFFF;
        fb   = d ^ c[w-1];
        return ((c << 1) ^ (fb ? poly : 16'h0000)) & mask;
    endfunction
`endif

    function automatic logic [98:0] rand99();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[98:0];
    endfunction

    function automatic logic [98:0] make_pkt(input logic [3:0] pid, input logic [82:0] pay);
        logic [98:0] p;
        p[98:91] = 8'b0000_0001;
        p[90] = pid[0];  p[89] = pid[1];  p[88] = pid[2];  p[87] = pid[3];
        p[86] = ~pid[0]; p[85] = ~pid[1]; p[84] = ~pid[2]; p[83] = ~pid[3];
        p[82:0] = pay;
        return p;
    endfunction

    function automatic logic [98:0] tok_pkt(input logic [3:0] pid, input logic [6:0] addr,
                                            input logic [3:0] endp, input logic [4:0] crcf);
        logic [82:0] pay;
        pay = rand99()[82:0];
        for (int i = 0; i < 7; i++) pay[82-i] = addr[i];
        for (int i = 0; i < 4; i++) pay[75-i] = endp[i];
        pay[71:67] = crcf;
        return make_pkt(pid, pay);
    endfunction

    function automatic logic [98:0] data_pkt(input logic [3:0] pid, input logic [63:0] d,
                                             input logic [15:0] crcf);
        logic [82:0] pay;
        pay = rand99()[82:0];
        pay[82:19] = d;
        pay[18:3]  = crcf;
        return make_pkt(pid, pay);
    endfunction

    // Expected per-cycle outputs from the first wire bit through DONE.
    task automatic push_packet(input logic [98:0] p, output bit ok);
        logic [3:0]  pid;
        int          len, run;
        logic        lvl;
        bit          b;
        logic [15:0] crc;
        pid = {p[87], p[88], p[89], p[90]};
        ok  = 1'b1;
        case (pid)
            4'b0001, 4'b1001: begin len = 32; mdl_plen = 11; mdl_clen = 5;  end
            4'b0011, 4'b1011: begin len = 96; mdl_plen = 64; mdl_clen = 16; end
            4'b0010, 4'b1010: begin len = 16; mdl_plen = 0;  mdl_clen = 0;  end
            default: begin len = 0; ok = 1'b0; end
        endcase
        if (!ok) begin
            sb.push_back(E_ERR);
            return;
        end
        mdl_body.delete();
        for (int i = 0; i < len; i++) mdl_body.push_back(p[98-i]);
`ifdef USB_ENC_CRC_EN
        crc = (mdl_clen == 5) ? 16'h001F : 16'hFFFF;
        for (int i = 16; i < 16 + mdl_plen; i++) crc = crc_step(crc, mdl_body[i], mdl_clen);
        for (int i = 0; i < mdl_clen; i++) mdl_body[16+mdl_plen+i] = ~crc[mdl_clen-1-i];
`endif
        run = 0;
        lvl = 1'b1;
        for (int i = 0; i < len; i++) begin
            b   = mdl_body[i];
            lvl = b ? lvl : ~lvl;
            sb.push_back({2'b11, lvl, ~lvl, 2'b00});
            run = b ? run + 1 : 0;
            if (run == STUFF_RUN) begin
                lvl = ~lvl;
                sb.push_back({2'b11, lvl, ~lvl, 2'b00});
                run = 0;
            end
        end
        for (int i = 0; i < EOP_SE0_LEN; i++) sb.push_back(E_SE0);
        sb.push_back(E_J);
        sb.push_back(E_DONE);
    endtask

    // NRZI-decode and destuff the captured wire levels, compare against the packet.
    task automatic decode_check(input string tag, input int exp_pre);
        bit   dec[$];
        bit   b;
        logic prev;
        int   run, n_pre, n_bad, n_mis, pay_end;
        prev = 1'b1; run = 0; n_pre = 0; n_bad = 0; n_mis = 0;
        pay_end = 16 + mdl_plen;
        foreach (cap[k]) begin
            b    = (cap[k] == prev);
            prev = cap[k];
            if (run == STUFF_RUN) begin
                run = 0;
                if (b) n_bad++;
                if (dec.size() <= pay_end) n_pre++;
            end else begin
                dec.push_back(b);
                run = b ? run + 1 : 0;
            end
        end
        check_eq({tag, "_len"}, 32'(dec.size()), 32'(mdl_body.size()));
        for (int i = 0; i < dec.size() && i < mdl_body.size(); i++)
            if (dec[i] != mdl_body[i]) n_mis++;
        check_eq({tag, "_bits"}, 32'(n_mis), 32'd0);
        check_eq({tag, "_stuffbit"}, 32'(n_bad), 32'd0);
        if (exp_pre >= 0) check_eq({tag, "_stuffs_pre_crc"}, 32'(n_pre), 32'(exp_pre));
`ifdef USB_ENC_CRC_EN
        if (mdl_clen != 0) begin
            logic [15:0] r;
            r = (mdl_clen == 5) ? 16'h001F : 16'hFFFF;
            for (int i = 16; i < pay_end + mdl_clen && i < dec.size(); i++)
                r = crc_step(r, dec[i], mdl_clen);
            check_eq({tag, "_crc_residual"}, 32'(r), (mdl_clen == 5) ? 32'h000C : 32'h800D);
        end
`endif
    endtask

    always @(negedge clk) begin
        logic [5:0] e;
        cyc <= cyc + 1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq($sformatf("line@%0d", cyc), 32'(obs), 32'(e));
        end
        if (!bus_oe) se0_seen <= 1'b0;
        else if (!dp && !dm) se0_seen <= 1'b1;
        else if (!se0_seen && (dp != dm)) cap.push_back(dp);
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
        check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic send_pkt(input logic [98:0] p, input string tag, input int exp_pre);
        bit ok;
        @(posedge clk); #1;
        pkt_in       = p;
        pkt_in_avail = 1'b1;
        cap.delete();
        sb.push_back(E_IDLE);
        push_packet(p, ok);
        sb.push_back(E_IDLE);
        sb.push_back(E_IDLE);
        @(posedge clk); #1;
        pkt_in_avail = 1'b0;
        pkt_in       = rand99();
        drain(tag);
        if (ok) decode_check(tag, exp_pre);
    endtask

    task automatic reset_mid();
        logic [98:0] p;
        bit          ok;
        p = data_pkt(4'b1011, {$urandom, $urandom}, 16'h5A3C);
        @(posedge clk); #1;
        pkt_in       = p;
        pkt_in_avail = 1'b1;
        sb.push_back(E_IDLE);
        push_packet(p, ok);
        @(posedge clk); #1;
        pkt_in_avail = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst_b = 1'b0;
        #1 check_eq("rst_mid_line", 32'(obs), 32'(E_IDLE));
        sb.delete();
        repeat (4) sb.push_back(E_IDLE);
        @(posedge clk);
        #2 rst_b = 1'b1;
        drain("rst_mid");
    endtask

    task automatic back_to_back();
        logic [98:0] a, junk;
        bit          ok;
        a    = make_pkt(4'b0010, rand99()[82:0]);
        junk = rand99();
        @(posedge clk); #1;
        pkt_in       = a;
        pkt_in_avail = 1'b1;
        sb.push_back(E_IDLE);
        push_packet(a, ok);
        sb.push_back(E_IDLE);
        push_packet(a, ok);
        sb.push_back(E_IDLE);
        sb.push_back(E_IDLE);
        repeat (5) @(posedge clk);
        #1 pkt_in = junk;
        repeat (10) @(posedge clk);
        #1 pkt_in = a;
        repeat (7) @(posedge clk);
        #1 pkt_in_avail = 1'b0;
        drain("b2b");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b        = 1'b0;
        pkt_in_avail = 1'b0;
        pkt_in       = '0;
        #12 check_eq("reset", 32'(obs), 32'(E_IDLE));
        @(negedge clk);
        rst_b = 1'b1;

        send_pkt(make_pkt(4'b0010, '0), "ack", -1);
        send_pkt(tok_pkt(4'b1001, 7'h05, 4'h1, 5'b10110), "in_tok", -1);
        send_pkt(data_pkt(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 16'hA5C3), "data0_ones", 11);
        send_pkt(data_pkt(4'b1011, {$urandom, $urandom}, 16'h1234), "data1", -1);
        send_pkt(tok_pkt(4'b0001, 7'h7F, 4'hF, 5'b11111), "out_tok", -1);
        send_pkt(make_pkt(4'b1010, rand99()[82:0]), "nak", -1);
        send_pkt(make_pkt(4'b0000, rand99()[82:0]), "bad_pid0", -1);
        send_pkt(make_pkt(4'b0111, rand99()[82:0]), "bad_pid7", -1);
        reset_mid();
        send_pkt(make_pkt(4'b0010, '0), "ack_after_rst", -1);
        back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
